// File: rtl/aes_main_pkg.sv
// rtl/aes_main_pkg.sv - shared types, constants and GF(2^8) helpers for the AES-128 engine
package aes_main_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ROUND,
        DONE,
        KEYREQ
    } aes_state_e;

    localparam int NR    = 10;
    localparam int KEY_W = 128;
    localparam int BLK_W = 128;

    // Index 0 is unused so the table can be indexed directly by round number.
    localparam logic [10:0][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_main_block_sbox.sv
// rtl/aes_main_block_sbox.sv - aes_sbox: combinational AES S-box (GF(2^8) inverse + affine)
module aes_sbox
    import aes_main_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] sq;
    logic [7:0] inv;

    // Inverse as din^254 = product of din^(2^k), k=1..7; maps 0 to 0 as required.
    always_comb begin
        sq  = din;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_main_block.sv
// rtl/aes_main_block.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key schedule
// Optional key rotation after KEY_BLOCKS consumed blocks is enabled by AES_KEY_ROTATE_EN.
module aes_main_block
    import aes_main_pkg::*;
#(
    parameter int KEY_BLOCKS = 8
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               data_in_stb,
    input  logic               data_out_stb,
    input  logic [BLK_W-1:0]   data_in,
    input  logic [7:0]         password,
    input  logic               usr_long_key_ch,
    output logic               usr_long_key_valid,
    output logic               usr_long_key_change_rq,
    output logic               ready,
    output logic               ready_for_transmit,
    output logic [BLK_W-1:0]   data_out,
    output logic               data_valid
);

    aes_state_e       state;
    logic [BLK_W-1:0] st;
    logic [KEY_W-1:0] rk;
    logic [KEY_W-1:0] bk;
    logic [3:0]       rnd;
    logic [3:0]       blk_cnt;
    logic [3:0]       blk_next;

    logic [7:0]       sb_in  [16];
    logic [7:0]       sb_out [16];
    logic [7:0]       sr     [16];
    logic [7:0]       ks_in  [4];
    logic [7:0]       ks_out [4];
    logic [31:0]      temp;
    logic [31:0]      n0, n1, n2, n3;
    logic [KEY_W-1:0] next_key;
    logic [BLK_W-1:0] round_out;

    for (genvar g = 0; g < 16; g++) begin : g_data_sbox
        aes_sbox u_sbox (.din(sb_in[g]), .dout(sb_out[g]));
    end

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (.din(ks_in[g]), .dout(ks_out[g]));
    end

    // Byte i of the AES state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    always_comb begin
        for (int i = 0; i < 16; i++) sb_in[i] = st[127-8*i -: 8];
        ks_in[0] = rk[23:16];
        ks_in[1] = rk[15:8];
        ks_in[2] = rk[7:0];
        ks_in[3] = rk[31:24];
    end

    always_comb begin
        temp     = {ks_out[0] ^ RCON[rnd], ks_out[1], ks_out[2], ks_out[3]};
        n0       = rk[127:96] ^ temp;
        n1       = rk[95:64]  ^ n0;
        n2       = rk[63:32]  ^ n1;
        n3       = rk[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        logic [31:0] col;
        round_out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb_out[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            col = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
            round_out[127-32*c -: 32] = ((rnd == 4'(NR)) ? col : mix_column(col))
                                        ^ next_key[127-32*c -: 32];
        end
    end

    assign blk_next           = blk_cnt + 4'd1;
    assign ready              = (state == IDLE) & usr_long_key_valid & ~usr_long_key_change_rq;
    assign ready_for_transmit = (state == IDLE);

`ifndef AES_KEY_ROTATE_EN
    assign usr_long_key_change_rq = 1'b0;
    wire unused_key_ch = usr_long_key_ch;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state              <= INIT;
            st                 <= '0;
            rk                 <= '0;
            bk                 <= '0;
            rnd                <= '0;
            blk_cnt            <= '0;
            data_out           <= '0;
            data_valid         <= 1'b0;
            usr_long_key_valid <= 1'b0;
`ifdef AES_KEY_ROTATE_EN
            usr_long_key_change_rq <= 1'b0;
`endif
        end else begin
            case (state)
                INIT: begin
                    bk                 <= {16{password}};
                    usr_long_key_valid <= 1'b1;
                    state              <= IDLE;
                end
                IDLE: begin
                    if (data_in_stb && ready) begin
                        st    <= data_in ^ bk;
                        rk    <= bk;
                        rnd   <= 4'd1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    rk  <= next_key;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'(NR)) begin
                        data_out   <= round_out;
                        data_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (data_out_stb) begin
                        data_valid <= 1'b0;
                        if (blk_next == 4'(KEY_BLOCKS)) begin
`ifdef AES_KEY_ROTATE_EN
                            blk_cnt                <= blk_next;
                            usr_long_key_change_rq <= 1'b1;
                            usr_long_key_valid     <= 1'b0;
                            state                  <= KEYREQ;
`else
                            blk_cnt <= '0;
                            state   <= IDLE;
`endif
                        end else begin
                            blk_cnt <= blk_next;
                            state   <= IDLE;
                        end
                    end
                end
                KEYREQ: begin
`ifdef AES_KEY_ROTATE_EN
                    // rk still holds the round-10 key derived from bk by the last encryption.
                    if (usr_long_key_ch) begin
                        bk                     <= rk;
                        blk_cnt                <= '0;
                        usr_long_key_change_rq <= 1'b0;
                        usr_long_key_valid     <= 1'b1;
                        state                  <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_main_block.sv
// tb/tb_aes_main_block.sv - directed vector bench for aes_main_block
module tb_aes_main_block;

    logic         clk_in;
    logic         reset;
    logic         data_in_stb;
    logic         data_out_stb;
    logic [127:0] data_in;
    logic [7:0]   password;
    logic         usr_long_key_ch;
    logic         usr_long_key_valid;
    logic         usr_long_key_change_rq;
    logic         ready;
    logic         ready_for_transmit;
    logic [127:0] data_out;
    logic         data_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [5];

    aes_main_block #(.KEY_BLOCKS(8)) dut (
        .clk_in                 (clk_in),
        .reset                  (reset),
        .data_in_stb            (data_in_stb),
        .data_out_stb           (data_out_stb),
        .data_in                (data_in),
        .password               (password),
        .usr_long_key_ch        (usr_long_key_ch),
        .usr_long_key_valid     (usr_long_key_valid),
        .usr_long_key_change_rq (usr_long_key_change_rq),
        .ready                  (ready),
        .ready_for_transmit     (ready_for_transmit),
        .data_out               (data_out),
        .data_valid             (data_valid)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!ready && w < 50) begin
            @(negedge clk_in);
            w++;
        end
        check1("ready_before_accept", ready, 1'b1);
    endtask

    task automatic encrypt(input logic [127:0] pt, output logic [127:0] ct, output int lat);
        wait_ready();
        data_in     = pt;
        data_in_stb = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        data_in_stb = 1'b0;
        data_in     = '1;
        lat = 0;
        while (!data_valid && lat < 40) begin
            @(posedge clk_in);
            lat++;
            @(negedge clk_in);
        end
        ct = data_out;
    endtask

    task automatic consume();
        data_out_stb = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        data_out_stb = 1'b0;
        check1("valid_after_consume", data_valid, 1'b0);
    endtask

    localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [127:0] ct;
        logic [127:0] held;
        int           lat;

        vecs[0] = '{pt: 128'h0,                                ct: CT_ZERO};
        vecs[1] = '{pt: 128'h80000000000000000000000000000000, ct: 128'h3ad78e726c1ec02b7ebfe92b23d9ec34};
        vecs[2] = '{pt: 128'hf34481ec3cc627bacd5dc3fb08f273e6, ct: 128'h0336763e966d92595a567cc9ce537f5e};
        vecs[3] = '{pt: 128'h9798c4640bad75c7c3227db910174e72, ct: 128'ha9a1631bf4996954ebc093957b234589};
        vecs[4] = '{pt: 128'h96ab5c2ff612d9dfaae8c31f30c42168, ct: 128'hff4f8391a6a40ca5b25d23bedd44a597};

        reset           = 1'b0;
        data_in_stb     = 1'b0;
        data_out_stb    = 1'b0;
        data_in         = '0;
        password        = 8'h00;
        usr_long_key_ch = 1'b0;

        repeat (3) @(negedge clk_in);
        check128("rst_data_out", data_out, 128'h0);
        check1("rst_data_valid", data_valid, 1'b0);
        check1("rst_ready", ready, 1'b0);
        check1("rst_rft", ready_for_transmit, 1'b0);
        check1("rst_key_valid", usr_long_key_valid, 1'b0);
        check1("rst_key_rq", usr_long_key_change_rq, 1'b0);

        reset = 1'b1;
        #1;
        check1("init_ready_low", ready, 1'b0);
        @(negedge clk_in);
        check1("init_key_valid", usr_long_key_valid, 1'b1);
        check1("init_ready", ready, 1'b1);
        check1("init_rft", ready_for_transmit, 1'b1);

        // Acknowledge outside KEYREQ must not disturb the key.
        usr_long_key_ch = 1'b1;
        @(negedge clk_in);
        usr_long_key_ch = 1'b0;

        for (int i = 0; i < 5; i++) begin
            encrypt(vecs[i].pt, ct, lat);
            check128($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
            check_int($sformatf("vec%0d_latency", i), lat, 10);
            consume();
        end

        // Block 6: output held while the host stalls.
        encrypt(vecs[0].pt, ct, lat);
        held = ct;
        check128("stall_first_ct", held, CT_ZERO);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            check1("stall_valid", data_valid, 1'b1);
            check128("stall_data", data_out, held);
            check1("stall_ready", ready, 1'b0);
            check1("stall_rft", ready_for_transmit, 1'b0);
        end
        consume();

        // Block 7: strobes pre-asserted; consume on the edge after valid, no accept on it.
        wait_ready();
        data_out_stb = 1'b1;
        data_in      = vecs[1].pt;
        data_in_stb  = 1'b1;
        @(posedge clk_in);
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (e == 9)  check1("pre_valid_e9", data_valid, 1'b0);
            if (e == 10) begin
                check1("pre_valid_e10", data_valid, 1'b1);
                check128("pre_ct_e10", data_out, vecs[1].ct);
            end
            if (e == 11) begin
                check1("pre_valid_e11", data_valid, 1'b0);
                check1("pre_rft_e11", ready_for_transmit, 1'b1);
            end
        end
        data_in_stb  = 1'b0;
        data_out_stb = 1'b0;

        // Block 8 reaches KEY_BLOCKS.
        encrypt(vecs[0].pt, ct, lat);
        check128("blk8_ct", ct, CT_ZERO);
        consume();
`ifdef AES_KEY_ROTATE_EN
        check1("keyreq_rq", usr_long_key_change_rq, 1'b1);
        check1("keyreq_valid", usr_long_key_valid, 1'b0);
        check1("keyreq_ready", ready, 1'b0);
        data_in_stb = 1'b1;
        repeat (2) @(negedge clk_in);
        data_in_stb = 1'b0;
        check1("keyreq_ignores_input", ready_for_transmit, 1'b0);
        usr_long_key_ch = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        usr_long_key_ch = 1'b0;
        check1("keyack_rq", usr_long_key_change_rq, 1'b0);
        check1("keyack_valid", usr_long_key_valid, 1'b1);
        check1("keyack_ready", ready, 1'b1);
        encrypt(vecs[0].pt, ct, lat);
        n_checks++;
        if (ct === CT_ZERO) begin
            n_fail++;
            $display("FAIL rotated_ct: got %h, required a value other than %h", ct, CT_ZERO);
        end
        consume();
`else
        check1("norot_rq", usr_long_key_change_rq, 1'b0);
        check1("norot_valid", usr_long_key_valid, 1'b1);
        check1("norot_ready", ready, 1'b1);
        usr_long_key_ch = 1'b1;
        @(negedge clk_in);
        usr_long_key_ch = 1'b0;
        encrypt(vecs[0].pt, ct, lat);
        check128("norot_ct", ct, CT_ZERO);
        consume();
`endif

        // Reset in the middle of an encryption.
        wait_ready();
        data_in     = vecs[2].pt;
        data_in_stb = 1'b1;
        @(posedge clk_in);
        data_in_stb = 1'b0;
        repeat (5) @(posedge clk_in);
        #2;
        reset = 1'b0;
        #1;
        check128("abort_data_out", data_out, 128'h0);
        check1("abort_valid", data_valid, 1'b0);
        check1("abort_ready", ready, 1'b0);
        check1("abort_rft", ready_for_transmit, 1'b0);
        check1("abort_key_valid", usr_long_key_valid, 1'b0);
        check1("abort_rq", usr_long_key_change_rq, 1'b0);
        @(negedge clk_in);
        reset = 1'b1;
        #1;
        check1("rerelease_ready_low", ready, 1'b0);
        @(negedge clk_in);
        check1("rerelease_ready", ready, 1'b1);
        encrypt(vecs[3].pt, ct, lat);
        check128("post_abort_ct", ct, vecs[3].ct);
        check_int("post_abort_latency", lat, 10);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
